// File: rtl/alu_defs.sv
// Shared ALU command codes and issue-controller state encoding.
package alu_defs;

   localparam logic [2:0] ADD_ALU  = 3'd0;
   localparam logic [2:0] SUB_ALU  = 3'd1;
   localparam logic [2:0] XOR_ALU  = 3'd2;
   localparam logic [2:0] SLT_ALU  = 3'd3;
   localparam logic [2:0] AND_ALU  = 3'd4;
   localparam logic [2:0] NAND_ALU = 3'd5;
   localparam logic [2:0] NOR_ALU  = 3'd6;
   localparam logic [2:0] OR_ALU   = 3'd7;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      RESP   = 2'd2
   } state_t;

   // Carry and overflow are only meaningful for the adder ops.
   function automatic logic is_arith(input logic [2:0] op);
      return (op == ADD_ALU) || (op == SUB_ALU);
   endfunction

endpackage

// File: rtl/alu_issue_ctrl_settle_timer.sv
// settle_timer: 4-bit loadable down-counter, done while enabled at zero.
module settle_timer (
   input  logic       clk,
   input  logic       reset,
   input  logic       load,
   input  logic [3:0] load_value,
   input  logic       en,
   output logic       done
);

   logic [3:0] r_count;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_count <= 4'd0;
      end else if (load) begin
         r_count <= load_value;
      end else if (en && (r_count != 4'd0)) begin
         r_count <= r_count - 4'd1;
      end
   end

   assign done = en & (r_count == 4'd0);

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller holding ALU inputs for a settle window, then sampling.
// Optional sticky overflow flag enabled by ALU_STICKY_OVF_EN.
module alu_issue_ctrl
   import alu_defs::*;
#(
   parameter int unsigned SETTLE_CYCLES = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [2:0]  req_op,
   input  logic [31:0] req_a,
   input  logic [31:0] req_b,
   output logic [2:0]  alu_command,
   output logic [31:0] alu_operandA,
   output logic [31:0] alu_operandB,
   input  logic [31:0] alu_result,
   input  logic        alu_carryout,
   input  logic        alu_zero,
   input  logic        alu_overflow,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_result,
   output logic        rsp_carryout,
   output logic        rsp_zero,
   output logic        rsp_overflow,
   output logic        busy
`ifdef ALU_STICKY_OVF_EN
   ,
   input  logic        ovf_clear,
   output logic        ovf_sticky
`endif
);

   localparam logic [3:0] LOAD_VAL = 4'(SETTLE_CYCLES - 1);

   state_t      r_state;
   logic [2:0]  r_cmd;
   logic [31:0] r_a;
   logic [31:0] r_b;
   logic [31:0] r_res;
   logic        r_c;
   logic        r_z;
   logic        r_o;

   logic w_accept;
   logic w_done;
   logic w_arith;
   logic w_settle;

   // Ready is held low while reset is asserted so every output reads 0.
   assign req_ready = ~reset
                    & ((r_state == IDLE)
                    | ((r_state == RESP) & rsp_ready));
   assign w_accept  = req_valid & req_ready;
   assign w_arith   = is_arith(r_cmd);
   assign w_settle  = (r_state == SETTLE);

   settle_timer u_timer (
      .clk        (clk),
      .reset      (reset),
      .load       (w_accept),
      .load_value (LOAD_VAL),
      .en         (w_settle),
      .done       (w_done)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
         r_cmd   <= ADD_ALU;
         r_a     <= 32'd0;
         r_b     <= 32'd0;
         r_res   <= 32'd0;
         r_c     <= 1'b0;
         r_z     <= 1'b0;
         r_o     <= 1'b0;
      end else if (w_accept) begin
         r_cmd   <= req_op;
         r_a     <= req_a;
         r_b     <= req_b;
         r_state <= SETTLE;
      end else begin
         unique case (r_state)
            SETTLE: begin
               if (w_done) begin
                  r_res   <= alu_result;
                  r_z     <= alu_zero;
                  r_c     <= w_arith & alu_carryout;
                  r_o     <= w_arith & alu_overflow;
                  r_state <= RESP;
               end
            end
            RESP: begin
               if (rsp_ready) r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign alu_command  = r_cmd;
   assign alu_operandA = r_a;
   assign alu_operandB = r_b;
   assign rsp_valid    = (r_state == RESP);
   assign rsp_result   = r_res;
   assign rsp_carryout = r_c;
   assign rsp_zero     = r_z;
   assign rsp_overflow = r_o;
   assign busy         = (r_state != IDLE);

`ifdef ALU_STICKY_OVF_EN
   logic r_sticky;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sticky <= 1'b0;
      end else if (w_done && w_arith && alu_overflow) begin
         r_sticky <= 1'b1;
      end else if (ovf_clear) begin
         r_sticky <= 1'b0;
      end
   end

   assign ovf_sticky = r_sticky;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl with a behavioural ALU plant.
module tb_alu_issue_ctrl;
   import alu_defs::*;

   localparam int S = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic [2:0]  req_op;
   logic [31:0] req_a;
   logic [31:0] req_b;
   logic [2:0]  alu_command;
   logic [31:0] alu_operandA;
   logic [31:0] alu_operandB;
   logic [31:0] alu_result;
   logic        alu_carryout;
   logic        alu_zero;
   logic        alu_overflow;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_result;
   logic        rsp_carryout;
   logic        rsp_zero;
   logic        rsp_overflow;
   logic        busy;
`ifdef ALU_STICKY_OVF_EN
   logic        ovf_clear;
   logic        ovf_sticky;
`endif

   always #5 clk = ~clk;

   alu_issue_ctrl #(.SETTLE_CYCLES(S)) dut (
      .clk          (clk),
      .reset        (reset),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_op       (req_op),
      .req_a        (req_a),
      .req_b        (req_b),
      .alu_command  (alu_command),
      .alu_operandA (alu_operandA),
      .alu_operandB (alu_operandB),
      .alu_result   (alu_result),
      .alu_carryout (alu_carryout),
      .alu_zero     (alu_zero),
      .alu_overflow (alu_overflow),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_result   (rsp_result),
      .rsp_carryout (rsp_carryout),
      .rsp_zero     (rsp_zero),
      .rsp_overflow (rsp_overflow),
      .busy         (busy)
`ifdef ALU_STICKY_OVF_EN
      ,
      .ovf_clear    (ovf_clear),
      .ovf_sticky   (ovf_sticky)
`endif
   );

   typedef struct packed {
      logic [31:0] r;
      logic        c;
      logic        z;
      logic        o;
   } res_t;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      res_t        e;
   } vec_t;

   // ALU plant: logic ops and SLT drive junk (1) on carry/overflow pins.
   function automatic res_t alu_raw(input logic [2:0] op,
                                    input logic [31:0] a,
                                    input logic [31:0] b);
      res_t        x;
      logic [32:0] s;
      x = '0;
      x.c = 1'b1;
      x.o = 1'b1;
      case (op)
         ADD_ALU: begin
            s = {1'b0, a} + {1'b0, b};
            x.r = s[31:0];
            x.c = s[32];
            x.o = (a[31] == b[31]) && (x.r[31] != a[31]);
         end
         SUB_ALU: begin
            s = {1'b0, a} + {1'b0, ~b} + 33'd1;
            x.r = s[31:0];
            x.c = s[32];
            x.o = (a[31] != b[31]) && (x.r[31] != a[31]);
         end
         XOR_ALU:  x.r = a ^ b;
         SLT_ALU:  x.r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         AND_ALU:  x.r = a & b;
         NAND_ALU: x.r = ~(a & b);
         NOR_ALU:  x.r = ~(a | b);
         default:  x.r = a | b;
      endcase
      x.z = (x.r == 32'd0);
      return x;
   endfunction

   function automatic res_t exp_of(input logic [2:0] op,
                                   input logic [31:0] a,
                                   input logic [31:0] b);
      res_t x;
      x = alu_raw(op, a, b);
      if (op != ADD_ALU && op != SUB_ALU) begin
         x.c = 1'b0;
         x.o = 1'b0;
      end
      return x;
   endfunction

   res_t w_alu;
   always_comb w_alu = alu_raw(alu_command, alu_operandA, alu_operandB);
   assign alu_result   = w_alu.r;
   assign alu_carryout = w_alu.c;
   assign alu_zero     = w_alu.z;
   assign alu_overflow = w_alu.o;

   int errs = 0;
   int chks = 0;

   task automatic chk(input string nm, input logic [95:0] act,
                      input logic [95:0] exp);
      chks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_op(input string nm, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input res_t e, input int hold);
      int n;
      n = 0;
      while (!req_ready && n < 20) begin
         step();
         n++;
      end
      chk({nm, " ready"}, 96'(req_ready), 96'd1);
      req_valid = 1'b1;
      req_op    = op;
      req_a     = a;
      req_b     = b;
      step();
      req_valid = 1'b0;
      req_a     = ~a;
      req_b     = ~b;
      chk({nm, " opnds"}, {alu_command, alu_operandA, alu_operandB},
          {op, a, b});
      n = 0;
      while (!rsp_valid && n < 40) begin
         step();
         n++;
      end
      chk({nm, " latency"}, 96'(n), 96'(S));
      chk({nm, " result"}, 96'(rsp_result), 96'(e.r));
      chk({nm, " flags"}, {rsp_carryout, rsp_zero, rsp_overflow},
          {e.c, e.z, e.o});
      repeat (hold) step();
      if (hold > 0)
         chk({nm, " hold"}, {rsp_valid, rsp_result, alu_operandA},
             {1'b1, e.r, a});
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      chk({nm, " done"}, {rsp_valid, busy}, 2'b00);
   endtask

   vec_t tbl [10];

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int          n;
      logic        stable;
      logic        seen;
      logic [2:0]  rop;
      logic [31:0] ra;
      logic [31:0] rb;

      tbl[0] = '{ADD_ALU,  32'hFFFFFFFF, 32'h00000001, '{32'h00000000, 1'b1, 1'b1, 1'b0}};
      tbl[1] = '{SUB_ALU,  32'h80000000, 32'h00000001, '{32'h7FFFFFFF, 1'b1, 1'b0, 1'b1}};
      tbl[2] = '{XOR_ALU,  32'h12345678, 32'h12345678, '{32'h00000000, 1'b0, 1'b1, 1'b0}};
      tbl[3] = '{SLT_ALU,  32'hFFFFFFFF, 32'h00000001, '{32'h00000001, 1'b0, 1'b0, 1'b0}};
      tbl[4] = '{AND_ALU,  32'hF0F0F0F0, 32'h0FF00FF0, '{32'h00F000F0, 1'b0, 1'b0, 1'b0}};
      tbl[5] = '{NAND_ALU, 32'hFFFFFFFF, 32'hFFFFFFFF, '{32'h00000000, 1'b0, 1'b1, 1'b0}};
      tbl[6] = '{NOR_ALU,  32'h00000000, 32'h00000000, '{32'hFFFFFFFF, 1'b0, 1'b0, 1'b0}};
      tbl[7] = '{OR_ALU,   32'h00000000, 32'h00000000, '{32'h00000000, 1'b0, 1'b1, 1'b0}};
      tbl[8] = '{ADD_ALU,  32'h7FFFFFFF, 32'h00000001, '{32'h80000000, 1'b0, 1'b0, 1'b1}};
      tbl[9] = '{SUB_ALU,  32'h00000005, 32'h00000005, '{32'h00000000, 1'b1, 1'b1, 1'b0}};

      reset     = 1'b1;
      req_valid = 1'b0;
      rsp_ready = 1'b0;
      req_op    = 3'd0;
      req_a     = 32'd0;
      req_b     = 32'd0;
`ifdef ALU_STICKY_OVF_EN
      ovf_clear = 1'b0;
`endif
      repeat (2) step();
      chk("reset ctl", {rsp_valid, req_ready, busy, alu_command},
          6'd0);
      chk("reset data", {alu_operandA, alu_operandB, rsp_result},
          96'd0);
      reset = 1'b0;
      #1;
      chk("reset ready", 96'(req_ready), 96'd1);

`ifdef ALU_STICKY_OVF_EN
      chk("sticky reset", 96'(ovf_sticky), 96'd0);
      do_op("sticky sub", SUB_ALU, 32'h80000000, 32'h1,
            '{32'h7FFFFFFF, 1'b1, 1'b0, 1'b1}, 0);
      chk("sticky set", 96'(ovf_sticky), 96'd1);
      do_op("sticky add", ADD_ALU, 32'h1, 32'h1,
            '{32'h2, 1'b0, 1'b0, 1'b0}, 0);
      chk("sticky keep", 96'(ovf_sticky), 96'd1);
      ovf_clear = 1'b1;
      step();
      ovf_clear = 1'b0;
      chk("sticky clear", 96'(ovf_sticky), 96'd0);
`endif

      for (int i = 0; i < 10; i++)
         do_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b,
               tbl[i].e, i % 3);

      req_valid = 1'b1;
      req_op    = SUB_ALU;
      req_a     = 32'h80000000;
      req_b     = 32'h00000001;
      step();
      req_valid = 1'b0;
      n = 0;
      while (!rsp_valid && n < 40) begin
         step();
         n++;
      end
      chk("bp latency", 96'(n), 96'(S));
      stable = 1'b1;
      for (int k = 0; k < 5; k++) begin
         step();
         stable = stable & rsp_valid & !req_ready
                & (rsp_result == 32'h7FFFFFFF)
                & (alu_operandA == 32'h80000000)
                & (alu_operandB == 32'h00000001);
      end
      chk("bp stable", 96'(stable), 96'd1);
      chk("bp flags", {rsp_carryout, rsp_zero, rsp_overflow}, 3'b101);
      rsp_ready = 1'b1;
      req_valid = 1'b1;
      req_op    = ADD_ALU;
      req_a     = 32'd1;
      req_b     = 32'd2;
      #1;
      chk("b2b ready", 96'(req_ready), 96'd1);
      step();
      rsp_ready = 1'b0;
      req_valid = 1'b0;
      chk("b2b accept",
          {rsp_valid, busy, alu_command, alu_operandA, alu_operandB},
          {1'b0, 1'b1, ADD_ALU, 32'd1, 32'd2});
      n = 0;
      while (!rsp_valid && n < 40) begin
         step();
         n++;
      end
      chk("b2b latency", 96'(n), 96'(S));
      chk("b2b result", {rsp_result, rsp_carryout, rsp_zero, rsp_overflow},
          {32'd3, 3'b000});
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;

      req_valid = 1'b1;
      req_op    = AND_ALU;
      req_a     = 32'hFFFF0000;
      req_b     = 32'h0F0F0F0F;
      step();
      req_valid = 1'b0;
      step();
      reset = 1'b1;
      #1;
      chk("midrst ctl",
          {rsp_valid, busy, req_ready, alu_command, alu_operandA},
          38'd0);
      chk("midrst data", {alu_operandB, rsp_result}, 64'd0);
      step();
      reset = 1'b0;
      #1;
      chk("midrst ready", 96'(req_ready), 96'd1);
      seen = 1'b0;
      for (int k = 0; k < 8; k++) begin
         step();
         seen = seen | rsp_valid | busy;
      end
      chk("midrst quiet", 96'(seen), 96'd0);

      for (int i = 0; i < 40; i++) begin
         rop = 3'($urandom_range(0, 7));
         ra  = $urandom;
         rb  = ($urandom_range(0, 3) == 0) ? ra : $urandom;
         do_op($sformatf("rnd%0d", i), rop, ra, rb, exp_of(rop, ra, rb),
               int'($urandom_range(0, 3)));
      end

      $display("Result: errors=%0d of %0d checks", errs, chks);
      $finish;
   end

endmodule
